mc_conn_arbiter: RTL and testbench
==================================

// Module: mc_conn_arbiter
// PURPOSE
// - Next-generation N-port switch arbiter. Grants multicast all-or-nothing with a round-robin pointer per output.
// - Holds each granted connection (owner, mux select, active flag) until the input signals end-of-packet.
// - Adds an aging reservation scheme that breaks the multicast livelock a per-output round-robin can fall into.
// - Sits between the input-port packet parsers and the output crossbar mux.
// PARAMETERS
// - NUM_PORTS  4   number of input ports and of output ports (2..16)
// - AGE_LIMIT  15  cycles a port may wait in WAIT before it becomes starved (1..255)
// - SEL_W      derived, max(1,$clog2(NUM_PORTS)); not overridable
// PORTS
// - clk          in   1              clock, rising edge
// - rst_n        in   1              asynchronous reset, active-low
// - req          in   NUM_PORTS      req[i]: input i requests a connection
// - dst          in   NUM_PORTS^2    dst[i*N+o]: input i targets output o (one-hot or multicast mask)
// - eop          in   NUM_PORTS      eop[i]: last beat of input i's packet; releases its outputs
// - grant        out  NUM_PORTS      1-cycle pulse: input i connected
// - conn         out  NUM_PORTS      level: input i currently owns its outputs
// - mux_sel      out  NUM_PORTS*SEL_W  mux_sel[o]: owning input index of output o
// - out_active   out  NUM_PORTS      output o is owned and forwarding
// - starve       out  NUM_PORTS      input i is the current reservation holder
// BEHAVIOUR
// - Reset (async, any time including mid-packet):
//   - all outputs 0, all port FSMs IDLE, RR pointers 0, age counters 0, no holder.
//   - An in-flight connection is dropped; no eop is needed afterwards.
// - Port FSM:
//   - IDLE -> WAIT when req & |dst.
//   - WAIT -> CONN on grant.
//   - CONN -> IDLE at the edge where eop=1.
//   - req with dst==0 is never granted and stays in IDLE.
// - req/dst are sampled every cycle in WAIT. dst must be held stable until grant; a change in WAIT restarts aging.
// - Dropping req in WAIT -> IDLE, age cleared.
// - Arbitration (combinational, cycle t; results registered at edge t+1):
//   - An output is free iff no CONN port owns it at t.
//   - For each free output, the RR winner among WAIT ports targeting it is picked, starting from ptr[o].
//   - Input i is granted iff every output in dst[i] is free and i wins each of them.
//   - Winners that are not granted keep nothing. ptr[o] does not move.
// - Registered results at edge t+1 for a granted input i:
//   - grant[i]=1 for exactly that cycle; conn[i]=1.
//   - For each o in dst[i]: mux_sel[o]=i, out_active[o]=1, ptr[o]=(i+1) mod N.
// - Release:
//   - eop[i] while conn[i]: at the next edge, conn[i]=0 and out_active=0 for i's outputs.
//   - mux_sel holds its last value.
//   - The freed outputs are arbitrable from the following cycle, so there is 1 idle cycle minimum between owners.
//   - eop while not conn is ignored.
//   - eop and req both high at a CONN port: the release is taken. req is then evaluated from IDLE on the next cycle.
// - Aging:
//   - age[i] increments each WAIT cycle without grant and saturates at AGE_LIMIT.
//   - The counter clears on grant or on leaving WAIT.
//   - Holder selection: when age[i]==AGE_LIMIT and no holder exists, the lowest-index such i becomes the holder (starve[i]=1).
// - Reservation:
//   - The holder's dst outputs are reserved. No other port may win a reserved output.
//   - The holder wins every free reserved output regardless of ptr.
//   - The holder is granted once all its outputs are free.
//   - The holder role clears on grant or when the holder leaves WAIT.
// - Multiple ports may be granted in the same cycle if their masks are disjoint. Two grants never share an output.
// - Latency: req in WAIT with all outputs free and uncontended -> grant one cycle later.
// TESTING
// - Unicast, N=4:
//   - req[0], dst0=0010 -> grant[0] pulse at t+1, mux_sel[1]=0, out_active=0010.
//   - eop[0] -> out_active=0000 next edge.
// - Multicast:
//   - p2 dst=1011, outputs idle -> single grant[2]; mux_sel[0]=mux_sel[1]=mux_sel[3]=2.
//   - ptr0=ptr1=ptr3=3.
// - Round robin:
//   - p0..p3 all dst=0001, each packet 1 beat -> grant order 0,1,2,3,0.
//   - 2 cycles per grant (grant + gap).
// - Livelock and aging:
//   - ptr0=0, ptr1=1; p0 dst=0011, p1 dst=0011 kept contended by a p3 stream.
//   - Expect starve[0] after 15 WAIT cycles, then grant[0] once outputs 0 and 1 are free.
//   - No p1 or p3 grant on outputs 0/1 meanwhile.
// - Disjoint parallel: p0 dst=0011, p1 dst=1100 same cycle -> grant=0011 same edge.
// - Reset mid-packet: rst_n low while conn=0101 -> all outputs 0 immediately; after release, req[0] is granted with no eop.

Source files
------------

// File: rtl/mc_conn_arbiter.sv
// Multicast connection arbiter between the input packet parsers and the output
// crossbar. Each input runs a small IDLE/WAIT/CONN FSM; every free output picks
// a round-robin winner among waiting inputs, and an input is connected only when
// it wins all of its targeted outputs. An aging reservation breaks the livelock
// where two multicast requests each win part of the other's outputs forever.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no request pending, owns no outputs
//   ST_WAIT | request pending, competing every cycle, age counter running
//   ST_CONN | owns its outputs until eop
module mc_conn_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int AGE_LIMIT = 15,
   localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_PORTS-1:0]         req_i,
   input  logic [NUM_PORTS*NUM_PORTS-1:0] dst_i,
   input  logic [NUM_PORTS-1:0]         eop_i,
   output logic [NUM_PORTS-1:0]         grant_o,
   output logic [NUM_PORTS-1:0]         conn_o,
   output logic [NUM_PORTS*SEL_W-1:0]   mux_sel_o,
   output logic [NUM_PORTS-1:0]         out_active_o,
   output logic [NUM_PORTS-1:0]         starve_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CONN} state_t;

   localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);

   state_t                 state_q [NUM_PORTS];
   state_t                 state_d [NUM_PORTS];
   logic [7:0]             age_q   [NUM_PORTS];
   logic [7:0]             age_d   [NUM_PORTS];
   logic [NUM_PORTS-1:0]   dst_q   [NUM_PORTS];
   logic [NUM_PORTS-1:0]   dst_v   [NUM_PORTS];
   logic [SEL_W-1:0]       ptr_q   [NUM_PORTS];
   logic [SEL_W-1:0]       ptr_d   [NUM_PORTS];
   logic [SEL_W-1:0]       mux_sel_q [NUM_PORTS];
   logic [SEL_W-1:0]       mux_sel_d [NUM_PORTS];
   logic [SEL_W-1:0]       win_idx [NUM_PORTS];
   logic [NUM_PORTS-1:0]   win_vld;
   logic [NUM_PORTS-1:0]   active;
   logic [NUM_PORTS-1:0]   res_mask;
   logic [NUM_PORTS-1:0]   grant_d, grant_q;
   logic [NUM_PORTS-1:0]   out_active_d, out_active_q;
   logic                   holder_vld_d, holder_vld_q;
   logic [SEL_W-1:0]       holder_d, holder_q;

   // Unpack the per-input destination masks.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) dst_v[i] = dst_i[i*NUM_PORTS +: NUM_PORTS];
   end

   // Per-output winner selection (reservation first, then round-robin) and all-or-nothing grant.
   always_comb begin
      int idx;
      idx = 0;
      for (int i = 0; i < NUM_PORTS; i++)
         active[i] = (state_q[i] == ST_WAIT) && req_i[i] && (|dst_v[i]);
      res_mask = '0;
      if (holder_vld_q && active[holder_q]) res_mask = dst_v[holder_q];
      for (int o = 0; o < NUM_PORTS; o++) begin
         win_vld[o] = 1'b0;
         win_idx[o] = '0;
         if (!out_active_q[o]) begin
            if (res_mask[o]) begin
               win_vld[o] = 1'b1;
               win_idx[o] = holder_q;
            end else begin
               for (int k = 0; k < NUM_PORTS; k++) begin
                  idx = (int'(ptr_q[o]) + k) % NUM_PORTS;
                  if (!win_vld[o] && active[idx] && dst_v[idx][o]) begin
                     win_vld[o] = 1'b1;
                     win_idx[o] = SEL_W'(idx);
                  end
               end
            end
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         grant_d[i] = active[i];
         for (int o = 0; o < NUM_PORTS; o++)
            if (dst_v[i][o] && (out_active_q[o] || !win_vld[o] || (win_idx[o] != SEL_W'(i))))
               grant_d[i] = 1'b0;
      end
   end

   // Port FSMs, aging, output ownership, round-robin pointers and reservation holder.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         state_d[i] = state_q[i];
         age_d[i]   = '0;
         case (state_q[i])
            ST_IDLE: if (req_i[i] && (|dst_v[i])) state_d[i] = ST_WAIT;
            ST_WAIT: begin
               if (grant_d[i])      state_d[i] = ST_CONN;
               else if (!active[i]) state_d[i] = ST_IDLE;
            end
            ST_CONN: if (eop_i[i]) state_d[i] = ST_IDLE;
            default: state_d[i] = ST_IDLE;
         endcase
         // A destination change while waiting restarts the age from zero.
         if (active[i] && !grant_d[i] && (dst_v[i] == dst_q[i]))
            age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + 8'd1;
      end

      out_active_d = out_active_q;
      for (int o = 0; o < NUM_PORTS; o++) begin
         mux_sel_d[o] = mux_sel_q[o];
         ptr_d[o]     = ptr_q[o];
         if (out_active_q[o] && eop_i[mux_sel_q[o]] && (state_q[mux_sel_q[o]] == ST_CONN))
            out_active_d[o] = 1'b0;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (grant_d[i] && dst_v[i][o]) begin
               mux_sel_d[o]    = SEL_W'(i);
               out_active_d[o] = 1'b1;
               ptr_d[o]        = SEL_W'((i + 1) % NUM_PORTS);
            end
         end
      end

      holder_vld_d = holder_vld_q;
      holder_d     = holder_q;
      if (holder_vld_q) begin
         if (grant_d[holder_q] || (state_d[holder_q] != ST_WAIT)) holder_vld_d = 1'b0;
      end else begin
         // Descending scan so the lowest-index starved port is the one kept.
         for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if ((state_q[i] == ST_WAIT) && (state_d[i] == ST_WAIT) && (age_q[i] == AGE_MAX)) begin
               holder_vld_d = 1'b1;
               holder_d     = SEL_W'(i);
            end
         end
      end
   end

   // State registers; reset drops any in-flight connection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            state_q[i]   <= ST_IDLE;
            age_q[i]     <= '0;
            dst_q[i]     <= '0;
            ptr_q[i]     <= '0;
            mux_sel_q[i] <= '0;
         end
         grant_q      <= '0;
         out_active_q <= '0;
         holder_vld_q <= 1'b0;
         holder_q     <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            state_q[i]   <= state_d[i];
            age_q[i]     <= age_d[i];
            dst_q[i]     <= dst_v[i];
            ptr_q[i]     <= ptr_d[i];
            mux_sel_q[i] <= mux_sel_d[i];
         end
         grant_q      <= grant_d;
         out_active_q <= out_active_d;
         holder_vld_q <= holder_vld_d;
         holder_q     <= holder_d;
      end
   end

   // Output packing.
   always_comb begin
      starve_o = '0;
      if (holder_vld_q) starve_o[holder_q] = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         conn_o[i]                    = (state_q[i] == ST_CONN);
         mux_sel_o[i*SEL_W +: SEL_W]  = mux_sel_q[i];
      end
      grant_o      = grant_q;
      out_active_o = out_active_q;
   end

endmodule

// File: tb/tb_mc_conn_arbiter.sv
// Directed bench for mc_conn_arbiter (N=4, AGE_LIMIT=15). Inputs are driven and
// outputs sampled on the falling edge, away from the active rising edge.
module tb_mc_conn_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req, eop;
   logic [15:0] dst;
   logic [3:0]  grant, conn, out_active, starve;
   logic [7:0]  mux_sel;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0] acc_grant, acc_starve;
   logic [3:0] rr_exp [10];

   always #5 clk = ~clk;

   mc_conn_arbiter #(.NUM_PORTS(4), .AGE_LIMIT(15)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req),
      .dst_i        (dst),
      .eop_i        (eop),
      .grant_o      (grant),
      .conn_o       (conn),
      .mux_sel_o    (mux_sel),
      .out_active_o (out_active),
      .starve_o     (starve)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_dst(input int i, input logic [3:0] m);
      dst[i*4 +: 4] = m;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      eop   = '0;
      dst   = '0;
      step(3);
      check("rst_grant", grant, 4'b0000);
      check("rst_conn", conn, 4'b0000);
      check("rst_active", out_active, 4'b0000);
      check("rst_starve", starve, 4'b0000);
      check("rst_muxsel", mux_sel, 8'h00);
      rst_n = 1'b1;
      step(1);

      // Unicast: p0 -> out1. IDLE->WAIT at first edge, grant at second.
      req[0] = 1'b1; set_dst(0, 4'b0010);
      step(1);
      check("uni_no_early_grant", grant, 4'b0000);
      step(1);
      check("uni_grant", grant, 4'b0001);
      check("uni_conn", conn, 4'b0001);
      check("uni_active", out_active, 4'b0010);
      check("uni_muxsel1", mux_sel[3:2], 2'd0);
      req[0] = 1'b0;
      step(1);
      check("uni_grant_pulse", grant, 4'b0000);
      check("uni_conn_held", conn, 4'b0001);
      eop[0] = 1'b1;
      step(1);
      eop[0] = 1'b0;
      check("uni_release_active", out_active, 4'b0000);
      check("uni_release_conn", conn, 4'b0000);

      // Livelock: ptr0=0, ptr1=1; p0 wins out0, p1 wins out1, neither granted until aging.
      req[0] = 1'b1; req[1] = 1'b1;
      set_dst(0, 4'b0011); set_dst(1, 4'b0011);
      step(1);
      acc_grant = '0; acc_starve = '0;
      for (int k = 1; k <= 15; k++) begin
         step(1);
         acc_grant  = acc_grant | grant;
         acc_starve = acc_starve | starve;
      end
      check("live_no_grant", acc_grant, 4'b0000);
      check("live_no_early_starve", acc_starve, 4'b0000);
      step(1);
      check("live_starve", starve, 4'b0001);
      check("live_grant_pending", grant, 4'b0000);
      step(1);
      check("live_grant", grant, 4'b0001);
      check("live_active", out_active, 4'b0011);
      check("live_starve_clear", starve, 4'b0000);
      req[1] = 1'b0; req[0] = 1'b0;
      step(1);
      eop[0] = 1'b1;
      step(1);
      eop[0] = 1'b0;
      check("live_release", out_active, 4'b0000);
      check("live_no_holder", starve, 4'b0000);

      // Multicast: p2 -> {0,1,3}.
      set_dst(0, 4'b0000); set_dst(1, 4'b0000);
      req[2] = 1'b1; set_dst(2, 4'b1011);
      step(2);
      check("mc_grant", grant, 4'b0100);
      check("mc_active", out_active, 4'b1011);
      check("mc_muxsel", mux_sel, 8'h8A);
      req[2] = 1'b0; set_dst(2, 4'b0000);
      eop[2] = 1'b1;
      step(1);
      eop[2] = 1'b0;
      check("mc_release", out_active, 4'b0000);

      // Round robin on out0 with ptr0=3 after the multicast: order 3,0,1,2,3.
      rr_exp = '{4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010,
                 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
      req = 4'b1111; eop = 4'b1111; dst = 16'h1111;
      step(1);
      for (int j = 0; j < 10; j++) begin
         step(1);
         check($sformatf("rr_grant_%0d", j), grant, rr_exp[j]);
      end
      req = '0;
      step(3);
      eop = '0; dst = '0;
      check("rr_idle", conn, 4'b0000);

      // Disjoint parallel grants; p3 with an empty mask is never granted.
      req = 4'b1011;
      set_dst(0, 4'b0011); set_dst(1, 4'b1100); set_dst(3, 4'b0000);
      step(2);
      check("dis_grant", grant, 4'b0011);
      check("dis_active", out_active, 4'b1111);
      req = '0;
      eop = 4'b0011;
      step(1);
      eop = '0;
      check("dis_release", out_active, 4'b0000);
      check("dis_zero_dst", conn, 4'b0000);

      // Reset mid-packet while conn=0101.
      dst = '0;
      req = 4'b0101; set_dst(0, 4'b0001); set_dst(2, 4'b0100);
      step(2);
      check("rst_mid_conn", conn, 4'b0101);
      req[2] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_conn0", conn, 4'b0000);
      check("rst_mid_active0", out_active, 4'b0000);
      step(2);
      rst_n = 1'b1;
      step(2);
      check("rst_regrant", grant, 4'b0001);
      check("rst_regrant_active", out_active, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
